cfi_shadow_stack: RTL and testbench
===================================

// Module: cfi_shadow_stack
// PURPOSE
//  Backward-edge CFI monitor: the return-side counterpart to the forward-edge landing-pad FSM.
//  Watches the committed instruction stream.
//  On every call it pushes the link address (pc+4) onto a private shadow stack.
//  On every return it pops that address and checks it against the actual resolved target.
//  Raises a registered, sticky CFI exception toward the commit/CSR logic on mismatch, underflow or overflow.
// PARAMETERS
//  XLEN   64  width of PC / return addresses
//  DEPTH  16  shadow-stack entries (>=2); DW = $clog2(DEPTH+1)
// PORTS
//  clk_i           in   1     clock
//  rst_ni          in   1     reset, asynchronous, active-low
//  en_i            in   1     CFI enable (from CSR); 0 = commits ignored, stack contents preserved
//  commit_valid_i  in   1     one instruction retires this cycle
//  commit_instr_i  in   32    retiring instruction (uncompressed)
//  commit_pc_i     in   XLEN  PC of retiring instruction
//  commit_npc_i    in   XLEN  resolved target / next PC of retiring instruction
//  fault_clear_i   in   1     clear fault and flush stack (trap handler / context switch)
//  ex_o            out  1     CFI exception pending (sticky)
//  ex_cause_o      out  2     0 none, 1 MISMATCH, 2 UNDERFLOW, 3 OVERFLOW
//  ex_tval_o       out  XLEN  faulting address (see below)
//  depth_o         out  DW    current number of valid entries
//  full_o          out  1     depth_o == DEPTH
//  empty_o         out  1     depth_o == 0
// BEHAVIOUR
//  Reset: state=RUN, depth=0, ex_o=0, ex_cause_o=0, ex_tval_o=0, empty_o=1, full_o=0.
//   Entry RAM contents are don't-care.
//  Decode applies only when commit_valid_i && en_i && state==RUN.
//   link(r) = (r==x1 || r==x5); rd=instr[11:7], rs1=instr[19:15].
//   JAL  (opcode 1101111): link(rd) -> PUSH.
//   JALR (opcode 1100111, funct3 000):
//    - !link(rd) && link(rs1)              -> POP
//    - link(rd) && !link(rs1)              -> PUSH
//    - link(rd) && link(rs1) && rd==rs1    -> PUSH
//    - link(rd) && link(rs1) && rd!=rs1    -> POP_THEN_PUSH (coroutine swap)
//   Anything else: no stack action.
//  PUSH value = commit_pc_i + 4, modulo 2^XLEN (wraps silently).
//  POP check: top entry compared with commit_npc_i.
//   Equal -> depth-1.
//   Not equal -> MISMATCH.
//  POP_THEN_PUSH: top compared, then replaced in place by pc+4; depth unchanged.
//   Legal when full; UNDERFLOW when empty.
//  Faults (state RUN->FAULT):
//   - MISMATCH: tval = commit_npc_i.
//   - UNDERFLOW (pop with depth==0): tval = commit_npc_i.
//   - OVERFLOW (push with depth==DEPTH): tval = pc+4.
//   Stack is never modified by a faulting instruction.
//  Latency: ex_o/ex_cause_o/ex_tval_o are registered and valid the cycle after the offending commit.
//   depth_o is updated the cycle after the commit.
//   Back-to-back commits are supported, 1 per cycle.
//   A pop directly following a push reads the just-pushed value (no bubble).
//  FAULT state: ex_o held 1, cause/tval frozen, all commits ignored.
//   Leaves only via fault_clear_i.
//  fault_clear_i (any state): next cycle state=RUN, depth=0, ex_o=0, cause=0, tval=0.
//   Priority over a same-cycle commit, which is dropped.
//  en_i deassertion mid-program: no flush.
//   Re-enable resumes with the preserved stack.
//  Reset mid-operation: immediate return to reset values regardless of state.
//  Implementation: a stack-pointer register plus an entry array.
//   No combinational path from commit_* to ex_o.
// TESTING
//  1. JAL x1 at pc=0x1000, then JALR x0,0(x1) with npc=0x1004
//     -> depth 1 then 0, ex_o stays 0.
//  2. Push at pc=0x1000, return with npc=0x2000
//     -> next cycle ex_o=1, cause=1, tval=0x2000, depth stays 1.
//  3. Return on an empty stack, npc=0x3000
//     -> ex_o=1, cause=2, tval=0x3000.
//     Then fault_clear_i -> ex_o=0, depth=0.
//  4. DEPTH pushes at pc=0x100*i, then one more push
//     -> full_o=1, then cause=3, depth stays DEPTH.
//     Subsequent commits are ignored while in FAULT.
//  5. Coroutine JALR x5,0(x1) on full stack, top=0x1004, npc=0x1004, pc=0x5000
//     -> no fault, depth=DEPTH, top=0x5004.
//  6. en_i=0 during a call/return pair; pc=2^XLEN-4 push wraps to tval/entry 0x0;
//     fault_clear_i coincident with a bad return -> no fault raised.

Source files
------------

// File: rtl/cfi_shadow_stack.sv
// cfi_shadow_stack: backward-edge CFI monitor using a private shadow stack of return addresses
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   en_i             CFI enable; when low, commits are ignored and the stack is preserved
//   commit_valid_i   one instruction retires this cycle
//   commit_instr_i   retiring instruction (uncompressed)
//   commit_pc_i      PC of the retiring instruction
//   commit_npc_i     resolved next PC / target of the retiring instruction
//   fault_clear_i    clear the fault and flush the stack
//   ex_o             sticky CFI exception pending
//   ex_cause_o       0 none, 1 mismatch, 2 underflow, 3 overflow
//   ex_tval_o        faulting address
//   depth_o          number of valid stack entries
//   full_o, empty_o  stack full / empty flags
module cfi_shadow_stack #(
    parameter  int XLEN  = 64,
    parameter  int DEPTH = 16,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            commit_valid_i,
    input  logic [31:0]     commit_instr_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic [XLEN-1:0] commit_npc_i,
    input  logic            fault_clear_i,
    output logic            ex_o,
    output logic [1:0]      ex_cause_o,
    output logic [XLEN-1:0] ex_tval_o,
    output logic [DW-1:0]   depth_o,
    output logic            full_o,
    output logic            empty_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_sp;
    logic [1:0]      r_cause;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_mem [DEPTH];

    function automatic logic f_link(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

    logic [4:0]      w_rd, w_rs1;
    logic            w_act, w_jal, w_jalr, w_lrd, w_lrs1;
    logic            w_push, w_pop, w_swap, w_empty, w_full;
    logic            w_under, w_mis, w_over, w_fault, w_we;
    logic [AW-1:0]   w_top_idx, w_widx;
    logic [XLEN-1:0] w_pc4, w_top;
    logic            w_unused;

    assign w_rd      = commit_instr_i[11:7];
    assign w_rs1     = commit_instr_i[19:15];
    assign w_unused  = &{1'b0, commit_instr_i[31:20], commit_instr_i[14:12]};
    // A cleared cycle drops the commit entirely.
    assign w_act     = commit_valid_i && en_i && r_state == RUN && !fault_clear_i;
    assign w_jal     = commit_instr_i[6:0] == 7'b1101111;
    assign w_jalr    = commit_instr_i[6:0] == 7'b1100111 && commit_instr_i[14:12] == 3'b000;
    assign w_lrd     = f_link(w_rd);
    assign w_lrs1    = f_link(w_rs1);
    assign w_push    = w_act && w_lrd && (w_jal || (w_jalr && (!w_lrs1 || w_rd == w_rs1)));
    assign w_pop     = w_act && w_jalr && !w_lrd && w_lrs1;
    assign w_swap    = w_act && w_jalr && w_lrd && w_lrs1 && w_rd != w_rs1;
    assign w_empty   = r_sp == '0;
    assign w_full    = r_sp == DW'(DEPTH);
    assign w_pc4     = commit_pc_i + XLEN'(4);
    assign w_top_idx = AW'(r_sp - DW'(1));
    assign w_top     = r_mem[w_top_idx];
    assign w_under   = (w_pop || w_swap) && w_empty;
    assign w_mis     = (w_pop || w_swap) && !w_empty && w_top != commit_npc_i;
    assign w_over    = w_push && w_full;
    assign w_fault   = w_under || w_mis || w_over;
    // Swap overwrites the top in place; push writes the slot above it.
    assign w_we      = (w_push || w_swap) && !w_fault;
    assign w_widx    = w_swap ? w_top_idx : AW'(r_sp);

    always_comb begin
        w_state_nxt = r_state;
        if (fault_clear_i)
            w_state_nxt = RUN;
        else if (r_state == RUN && w_fault)
            w_state_nxt = FAULT;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RUN;
            r_sp    <= '0;
            r_cause <= 2'd0;
            r_tval  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (fault_clear_i) begin
                r_sp    <= '0;
                r_cause <= 2'd0;
                r_tval  <= '0;
            end else if (w_fault) begin
                r_cause <= w_over ? 2'd3 : w_under ? 2'd2 : 2'd1;
                r_tval  <= w_over ? w_pc4 : commit_npc_i;
            end else if (w_push) begin
                r_sp <= r_sp + DW'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we)
            r_mem[w_widx] <= w_pc4;
    end

    assign ex_o       = r_state == FAULT;
    assign ex_cause_o = r_cause;
    assign ex_tval_o  = r_tval;
    assign depth_o    = r_sp;
    assign full_o     = w_full;
    assign empty_o    = w_empty;
endmodule

// File: tb/tb_cfi_shadow_stack.sv
// tb_cfi_shadow_stack: directed self-checking bench for the shadow-stack CFI monitor
module tb_cfi_shadow_stack;
    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            en_i;
    logic            commit_valid_i;
    logic [31:0]     commit_instr_i;
    logic [XLEN-1:0] commit_pc_i;
    logic [XLEN-1:0] commit_npc_i;
    logic            fault_clear_i;
    logic            ex_o;
    logic [1:0]      ex_cause_o;
    logic [XLEN-1:0] ex_tval_o;
    logic [DW-1:0]   depth_o;
    logic            full_o;
    logic            empty_o;

    int n_tot = 0;
    int n_bad = 0;

    cfi_shadow_stack #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .commit_valid_i(commit_valid_i), .commit_instr_i(commit_instr_i),
        .commit_pc_i(commit_pc_i), .commit_npc_i(commit_npc_i),
        .fault_clear_i(fault_clear_i), .ex_o(ex_o), .ex_cause_o(ex_cause_o),
        .ex_tval_o(ex_tval_o), .depth_o(depth_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] jal(input logic [4:0] rd);
        return {20'h0, rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    // One retiring instruction (or an idle cycle with v=0); returns #1 after the edge.
    task automatic cyc(input logic [31:0] instr, input logic [63:0] pc, input logic [63:0] npc,
                       input logic v, input logic clr);
        @(negedge clk_i);
        commit_valid_i = v;
        commit_instr_i = instr;
        commit_pc_i    = pc;
        commit_npc_i   = npc;
        fault_clear_i  = clr;
        @(posedge clk_i);
        #1;
        commit_valid_i = 1'b0;
        fault_clear_i  = 1'b0;
    endtask

    task automatic fill();
        for (int i = 1; i <= DEPTH; i++)
            cyc(jal(5'd1), 64'h100 * i, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic clear();
        cyc(32'h0, 64'h0, 64'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_ni = 1'b0; en_i = 1'b1; commit_valid_i = 1'b0; commit_instr_i = '0;
        commit_pc_i = '0; commit_npc_i = '0; fault_clear_i = 1'b0;
        #3;
        chk("rst_ex", ex_o, 0);
        chk("rst_cause", ex_cause_o, 0);
        chk("rst_tval", ex_tval_o, 0);
        chk("rst_depth", depth_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        #9 rst_ni = 1'b1;

        // call / matching return
        cyc(jal(5'd1), 64'h1000, 64'h2000, 1'b1, 1'b0);
        chk("t1_depth1", depth_o, 1);
        chk("t1_empty", empty_o, 0);
        cyc(jalr(5'd0, 5'd1), 64'h2000, 64'h1004, 1'b1, 1'b0);
        chk("t1_depth0", depth_o, 0);
        chk("t1_ex", ex_o, 0);

        // mismatch
        cyc(jal(5'd1), 64'h1000, 64'h2000, 1'b1, 1'b0);
        cyc(jalr(5'd0, 5'd1), 64'h1800, 64'h2000, 1'b1, 1'b0);
        chk("t2_ex", ex_o, 1);
        chk("t2_cause", ex_cause_o, 1);
        chk("t2_tval", ex_tval_o, 64'h2000);
        chk("t2_depth", depth_o, 1);
        clear();
        chk("t2_clr_ex", ex_o, 0);
        chk("t2_clr_cause", ex_cause_o, 0);
        chk("t2_clr_depth", depth_o, 0);

        // underflow
        cyc(jalr(5'd0, 5'd5), 64'h2800, 64'h3000, 1'b1, 1'b0);
        chk("t3_ex", ex_o, 1);
        chk("t3_cause", ex_cause_o, 2);
        chk("t3_tval", ex_tval_o, 64'h3000);
        clear();
        chk("t3_clr_ex", ex_o, 0);
        chk("t3_clr_depth", depth_o, 0);
        chk("t3_clr_tval", ex_tval_o, 0);

        // overflow, then commits ignored while faulted
        fill();
        chk("t4_full", full_o, 1);
        chk("t4_depth", depth_o, DEPTH);
        cyc(jal(5'd1), 64'h9000, 64'h0, 1'b1, 1'b0);
        chk("t4_ex", ex_o, 1);
        chk("t4_cause", ex_cause_o, 3);
        chk("t4_tval", ex_tval_o, 64'h9004);
        chk("t4_depth_ovf", depth_o, DEPTH);
        cyc(jalr(5'd0, 5'd1), 64'h9100, 64'h1004, 1'b1, 1'b0);
        chk("t4_ign_depth", depth_o, DEPTH);
        chk("t4_ign_cause", ex_cause_o, 3);
        chk("t4_ign_tval", ex_tval_o, 64'h9004);
        clear();

        // coroutine swap on a full stack (top = 0x1000+4), then unwind
        fill();
        cyc(jalr(5'd5, 5'd1), 64'h5000, 64'h1004, 1'b1, 1'b0);
        chk("t5_ex", ex_o, 0);
        chk("t5_depth", depth_o, DEPTH);
        cyc(jalr(5'd0, 5'd5), 64'h6000, 64'h5004, 1'b1, 1'b0);
        chk("t5_pop_ex", ex_o, 0);
        chk("t5_pop_depth", depth_o, DEPTH - 1);
        cyc(jalr(5'd0, 5'd1), 64'h6100, 64'h0f04, 1'b1, 1'b0);
        chk("t5_pop2_ex", ex_o, 0);
        chk("t5_pop2_depth", depth_o, DEPTH - 2);
        clear();

        // swap on empty stack underflows
        cyc(jalr(5'd1, 5'd5), 64'h7000, 64'h7777, 1'b1, 1'b0);
        chk("t6_swap_cause", ex_cause_o, 2);
        chk("t6_swap_tval", ex_tval_o, 64'h7777);
        clear();

        // disable: ignored commits, stack preserved
        en_i = 1'b0;
        cyc(jal(5'd1), 64'h1000, 64'h0, 1'b1, 1'b0);
        chk("t6_dis_push", depth_o, 0);
        en_i = 1'b1;
        cyc(jal(5'd1), 64'h1000, 64'h0, 1'b1, 1'b0);
        en_i = 1'b0;
        cyc(jalr(5'd0, 5'd1), 64'h2000, 64'hdead, 1'b1, 1'b0);
        chk("t6_dis_ex", ex_o, 0);
        chk("t6_dis_depth", depth_o, 1);
        en_i = 1'b1;
        cyc(jalr(5'd0, 5'd1), 64'h2000, 64'h1004, 1'b1, 1'b0);
        chk("t6_ren_ex", ex_o, 0);
        chk("t6_ren_depth", depth_o, 0);

        // pc+4 wraps to zero
        cyc(jal(5'd5), 64'hffff_ffff_ffff_fffc, 64'h0, 1'b1, 1'b0);
        chk("t6_wrap_depth", depth_o, 1);
        cyc(jalr(5'd0, 5'd5), 64'h40, 64'h0, 1'b1, 1'b0);
        chk("t6_wrap_ex", ex_o, 0);
        chk("t6_wrap_pop", depth_o, 0);

        // non-link JAL does nothing
        cyc(jal(5'd0), 64'h1000, 64'h0, 1'b1, 1'b0);
        chk("t6_jal_x0", depth_o, 0);

        // clear wins over a coincident bad return
        cyc(jal(5'd1), 64'h1000, 64'h0, 1'b1, 1'b0);
        cyc(jalr(5'd0, 5'd1), 64'h2000, 64'hbad0, 1'b1, 1'b1);
        chk("t6_clr_ex", ex_o, 0);
        chk("t6_clr_cause", ex_cause_o, 0);
        chk("t6_clr_depth", depth_o, 0);

        // asynchronous reset mid-operation
        cyc(jal(5'd1), 64'h1000, 64'h0, 1'b1, 1'b0);
        cyc(jalr(5'd0, 5'd1), 64'h2000, 64'hbad0, 1'b1, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst2_ex", ex_o, 0);
        chk("rst2_depth", depth_o, 0);
        chk("rst2_tval", ex_tval_o, 0);
        #2 rst_ni = 1'b1;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
